axist_csr_slave: RTL and testbench
==================================

Name: axist_csr_slave

Overview:
- AVMM responder for the AXI-Stream/AIB test CSR map; terminates the management master's 32-bit reads and writes.
- Drives the delay, packet-control and AXI-reset configuration outputs.
- Returns link, checker and captured 256-bit data status.
- Sits between the management AVMM interconnect and the AXI-Stream pattern generator/checker, in the single avmm_clk domain.

Parameters:
- BASE_ADDR, 32'h5000_0000, upper address bits [31:16] that must match for a hit.
- DELAY_W, 16, width of each delay output.
- DEF_DELAY_X, 12, reset value of DELAY_X.
- DEF_DELAY_Y, 32, reset value of DELAY_Y.
- DEF_DELAY_Z, 6000, reset value of DELAY_Z.

Ports:
- avmm_clk  in  1  CSR clock; all inputs are synchronous to it.
- avmm_rst  in  1  synchronous, active-high reset.
- i_address  in  32  byte address, word aligned.
- i_write  in  1  write request.
- i_read  in  1  read request.
- i_writedata  in  32  write data.
- o_readdata  out  32  read data, valid with o_readdatavalid.
- o_readdatavalid  out  1  one-cycle read response strobe.
- o_waitrequest  out  1  request stall.
- i_link_sts  in  4  {sl_rx_online, sl_tx_online, ms_rx_online, ms_tx_online}.
- i_align_done  in  1  checker alignment achieved.
- i_test_done  in  1  checker finished.
- i_test_pass  in  1  checker compare pass.
- i_dout_first, i_dout_last, i_din_first, i_din_last  in  256 each  first/last transmitted and received beats.
- o_delay_x, o_delay_y, o_delay_z  out  DELAY_W each  delay configuration.
- o_axi_rst  out  1  AXI interface reset.
- o_start  out  1  one-cycle test start pulse.
- o_pat_sel  out  2  pattern select.
- o_pkt_cnt  out  8  packet count.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x1000 TX_PKT_CTRL, RW.
    - [0] start: write 1 produces an o_start pulse the next cycle; reads 0.
    - [2:1] pat_sel; [15:8] pkt_cnt.
  - 0x1004 RX_CKR_STS, RO: [0] pass, [1] done, [3] align_done; other bits 0.
  - 0x1008 LINKUP_STS, RO: [3:0] i_link_sts.
  - 0x100C ERR, RW1C: [0] unmapped access, [1] read+write collision.
  - 0x2000, 0x2004, 0x2008 DELAY_X/Y/Z, RW, low DELAY_W bits.
  - 0x3000 AXI_CTRL, RW: [0] o_axi_rst.
  - 0x4000 DOUT_FIRST, 0x4100 DOUT_LAST, 0x4200 DIN_FIRST, 0x4300 DIN_LAST: RO windows of 8 words each (+0x00..+0x1C); word k = bits [32k+31:32k].
- Reset values:
  - o_waitrequest=1, o_readdatavalid=0, o_readdata=0, o_start=0.
  - o_pat_sel=0, o_pkt_cnt=0, o_axi_rst=0, ERR=0.
  - Delays = DEF_*; window shadows = 0.
- o_waitrequest deasserts the first cycle after avmm_rst falls.
- FSM states: IDLE, RD1, RD2.
  - IDLE: o_waitrequest=0. A request is accepted when (i_read|i_write) && !o_waitrequest.
  - Write accepted in cycle N: register updated at the edge ending N, visible from N+1. The FSM stays in IDLE, so back-to-back writes run at 1 per cycle.
  - Read accepted in cycle N: go to RD1 (waitrequest=1), then RD2. In RD2, o_readdatavalid=1 with o_readdata registered (latency 2); waitrequest=1.
  - After RD2, return to IDLE; next accept no earlier than N+3.
- Only one read is outstanding at a time. Status inputs are sampled in cycle N.
- i_read && i_write in the same cycle: the write is performed, the read is dropped (no readdatavalid), and ERR[1] is set.
- Address with [31:16] != BASE_ADDR[31:16], or an unlisted offset:
  - write is discarded;
  - read returns 0 with normal latency;
  - ERR[0] is set.
- Writes to RO registers are ignored and do not set ERR.
- Window coherence: a read of word 0 snapshots the full 256-bit input into that window's shadow; words 0–7 are served from the shadow. Reads of words 1–7 never re-snapshot. Shadows of the 4 windows are independent.
- ERR write-1-to-clear coinciding with a new error event in the same cycle: set wins.
- avmm_rst asserted mid-read (RD1/RD2): FSM returns to IDLE, no readdatavalid pulse, all registers return to reset values.

Decomposition:
- Package axist_csr_pkg holds:
  - register offset localparams (0x1000..0x4300);
  - field bit positions;
  - the FSM state enum;
  - the window base list.
- Sub-module axist_csr_win256 (snapshot shadow + 8:1 word mux), instantiated 4×.

Test Plan:
- Reset, then read 0x50002000/2004/2008 -> 0x0000000C, 0x00000020, 0x00001770; readdatavalid exactly 2 cycles after accept; waitrequest high in the 2 cycles after accept.
- Write 0x50001000 = 0x00001005 -> o_start high for exactly 1 cycle, o_pat_sel=2'b10, o_pkt_cnt=0x10; readback returns 0x00001004.
- i_link_sts=4'hF, i_align_done=1, i_test_done=1, i_test_pass=1 -> LINKUP_STS reads 0x0000000F; RX_CKR_STS reads 0x0000000B.
- i_dout_first = 256'h{0x77777777..0x00000000 per word}; read word 0, then change the input, then read words 1–7 -> the 8 reads reproduce the original value (assembled low word first).
- Read 0x50009000 -> readdata 0, ERR reads 0x1; write 0x1 to 0x5000100C -> ERR reads 0; simultaneous read+write to 0x50003000 with data 1 -> o_axi_rst=1, no readdatavalid, ERR[1]=1.
- Assert avmm_rst during RD1 -> no readdatavalid pulse, waitrequest=1 during reset, delays back to defaults.

Source files
------------

// File: rtl/axist_csr_pkg.sv
// Shared definitions for the AXI-Stream/AIB test CSR responder: register
// offsets, field positions, FSM state encoding and capture-window bases.
package axist_csr_pkg;

  // Register offsets relative to BASE_ADDR (low 16 address bits)
  localparam logic [15:0] OFF_TX_PKT_CTRL = 16'h1000;
  localparam logic [15:0] OFF_RX_CKR_STS  = 16'h1004;
  localparam logic [15:0] OFF_LINKUP_STS  = 16'h1008;
  localparam logic [15:0] OFF_ERR         = 16'h100C;
  localparam logic [15:0] OFF_DELAY_X     = 16'h2000;
  localparam logic [15:0] OFF_DELAY_Y     = 16'h2004;
  localparam logic [15:0] OFF_DELAY_Z     = 16'h2008;
  localparam logic [15:0] OFF_AXI_CTRL    = 16'h3000;
  localparam logic [15:0] OFF_DOUT_FIRST  = 16'h4000;
  localparam logic [15:0] OFF_DOUT_LAST   = 16'h4100;
  localparam logic [15:0] OFF_DIN_FIRST   = 16'h4200;
  localparam logic [15:0] OFF_DIN_LAST    = 16'h4300;

  // Capture windows: 8 words each, index 0..3 = dout_first, dout_last,
  // din_first, din_last
  localparam int NUM_WIN = 4;
  localparam logic [NUM_WIN-1:0][15:0] WIN_BASE =
    {OFF_DIN_LAST, OFF_DIN_FIRST, OFF_DOUT_LAST, OFF_DOUT_FIRST};

  // Field bit positions
  localparam int TX_START_BIT     = 0;
  localparam int TX_PATSEL_LSB    = 1;
  localparam int TX_PKTCNT_LSB    = 8;
  localparam int CKR_PASS_BIT     = 0;
  localparam int CKR_DONE_BIT     = 1;
  localparam int CKR_ALIGN_BIT    = 3;
  localparam int ERR_UNMAPPED_BIT = 0;
  localparam int ERR_COLLIDE_BIT  = 1;
  localparam int AXI_RST_BIT      = 0;

  // Read-response FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2
  } state_e;

endpackage

// File: rtl/axist_csr_win256.sv
// One 256-bit capture window: a snapshot shadow loaded when word 0 is read,
// and an 8:1 word mux serving reads from the shadow.
module axist_csr_win256 (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [255:0] din_i,
  input  logic         snap_i,
  input  logic [2:0]   word_i,
  output logic [31:0]  rdata_o
);

  logic [255:0] shadow_q;
  logic [255:0] shadow_d;
  logic [255:0] src;

  // Load the whole beat on a word-0 read so words 1..7 stay coherent with it
  always_comb begin
    shadow_d = shadow_q;
    if (snap_i) shadow_d = din_i;
  end

  // Shadow register
  always_ff @(posedge clk_i) begin
    if (rst_i) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  // The word-0 read itself returns the live beat that is being captured
  assign src     = snap_i ? din_i : shadow_q;
  assign rdata_o = src[{word_i, 5'b00000} +: 32];

endmodule

// File: rtl/axist_csr_slave.sv
// AVMM CSR responder for the AXI-Stream/AIB test block. Writes complete in
// the accept cycle; reads return o_readdatavalid two cycles after accept.
//
// Handshake: a request is accepted in a cycle where (i_read | i_write) is
// high and o_waitrequest is low. o_waitrequest is high during reset, in the
// first cycle after reset, and in the two cycles following a read accept.
// o_readdata is meaningful only while o_readdatavalid is high.
module axist_csr_slave
  import axist_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
  parameter int          DELAY_W     = 16,
  parameter int          DEF_DELAY_X = 12,
  parameter int          DEF_DELAY_Y = 32,
  parameter int          DEF_DELAY_Z = 6000
) (
  input  logic               avmm_clk,
  input  logic               avmm_rst,
  input  logic [31:0]        i_address,
  input  logic               i_write,
  input  logic               i_read,
  input  logic [31:0]        i_writedata,
  output logic [31:0]        o_readdata,
  output logic               o_readdatavalid,
  output logic               o_waitrequest,
  input  logic [3:0]         i_link_sts,
  input  logic               i_align_done,
  input  logic               i_test_done,
  input  logic               i_test_pass,
  input  logic [255:0]       i_dout_first,
  input  logic [255:0]       i_dout_last,
  input  logic [255:0]       i_din_first,
  input  logic [255:0]       i_din_last,
  output logic [DELAY_W-1:0] o_delay_x,
  output logic [DELAY_W-1:0] o_delay_y,
  output logic [DELAY_W-1:0] o_delay_z,
  output logic               o_axi_rst,
  output logic               o_start,
  output logic [1:0]         o_pat_sel,
  output logic [7:0]         o_pkt_cnt,
  output logic [1:0]         o_dbg_state
);

  state_e             state_q, state_d;
  logic               wait_q, wait_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               start_q, start_d;
  logic [1:0]         pat_sel_q, pat_sel_d;
  logic [7:0]         pkt_cnt_q, pkt_cnt_d;
  logic               axi_rst_q, axi_rst_d;
  logic [1:0]         err_q, err_d, err_set, err_clr;
  logic [DELAY_W-1:0] delay_x_q, delay_x_d;
  logic [DELAY_W-1:0] delay_y_q, delay_y_d;
  logic [DELAY_W-1:0] delay_z_q, delay_z_d;

  logic [15:0]              off;
  logic                     hit, acc, acc_wr, acc_rd, collide;
  logic                     mapped;
  logic [31:0]              rd_mux;
  logic [NUM_WIN-1:0]       win_hit;
  logic [2:0]               win_word;
  logic [NUM_WIN-1:0][31:0] win_rdata;
  logic [NUM_WIN-1:0][255:0] win_din;
  logic                     unused_wdata;

  assign off      = i_address[15:0];
  assign hit      = (i_address[31:16] == BASE_ADDR[31:16]);
  assign acc      = (i_read | i_write) && !wait_q && (state_q == IDLE);
  assign acc_wr   = acc && i_write;
  assign collide  = acc && i_read && i_write;
  assign acc_rd   = acc && i_read && !i_write;
  assign win_word = off[4:2];
  assign win_din  = {i_din_last, i_din_first, i_dout_last, i_dout_first};
  assign unused_wdata = ^i_writedata;

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    assign win_hit[w] = hit && (off[15:5] == WIN_BASE[w][15:5]) && (off[1:0] == 2'b00);
    axist_csr_win256 u_win (
      .clk_i   (avmm_clk),
      .rst_i   (avmm_rst),
      .din_i   (win_din[w]),
      .snap_i  (acc_rd && win_hit[w] && (win_word == 3'd0)),
      .word_i  (win_word),
      .rdata_o (win_rdata[w])
    );
  end

  // Address decode and read-data mux; unmapped addresses read as zero
  always_comb begin
    mapped = 1'b0;
    rd_mux = '0;
    if (hit) begin
      case (off)
        OFF_TX_PKT_CTRL: begin
          mapped = 1'b1;
          rd_mux[TX_PATSEL_LSB +: 2] = pat_sel_q;
          rd_mux[TX_PKTCNT_LSB +: 8] = pkt_cnt_q;
        end
        OFF_RX_CKR_STS: begin
          mapped = 1'b1;
          rd_mux[CKR_PASS_BIT]  = i_test_pass;
          rd_mux[CKR_DONE_BIT]  = i_test_done;
          rd_mux[CKR_ALIGN_BIT] = i_align_done;
        end
        OFF_LINKUP_STS: begin
          mapped      = 1'b1;
          rd_mux[3:0] = i_link_sts;
        end
        OFF_ERR: begin
          mapped      = 1'b1;
          rd_mux[1:0] = err_q;
        end
        OFF_DELAY_X: begin
          mapped = 1'b1;
          rd_mux = 32'(delay_x_q);
        end
        OFF_DELAY_Y: begin
          mapped = 1'b1;
          rd_mux = 32'(delay_y_q);
        end
        OFF_DELAY_Z: begin
          mapped = 1'b1;
          rd_mux = 32'(delay_z_q);
        end
        OFF_AXI_CTRL: begin
          mapped              = 1'b1;
          rd_mux[AXI_RST_BIT] = axi_rst_q;
        end
        default: ;
      endcase
      for (int w = 0; w < NUM_WIN; w++) begin
        if (win_hit[w]) begin
          mapped = 1'b1;
          rd_mux = win_rdata[w];
        end
      end
    end
  end

  // FSM next state, register writes and error tracking
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    start_d   = 1'b0;
    pat_sel_d = pat_sel_q;
    pkt_cnt_d = pkt_cnt_q;
    axi_rst_d = axi_rst_q;
    delay_x_d = delay_x_q;
    delay_y_d = delay_y_q;
    delay_z_d = delay_z_q;
    err_set   = '0;
    err_clr   = '0;

    case (state_q)
      IDLE: begin
        if (acc_rd) begin
          state_d = RD1;
          rdata_d = rd_mux;
        end
      end
      RD1:     state_d = RD2;
      RD2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (acc_wr && hit) begin
      case (off)
        OFF_TX_PKT_CTRL: begin
          start_d   = i_writedata[TX_START_BIT];
          pat_sel_d = i_writedata[TX_PATSEL_LSB +: 2];
          pkt_cnt_d = i_writedata[TX_PKTCNT_LSB +: 8];
        end
        OFF_ERR:      err_clr   = i_writedata[1:0];
        OFF_DELAY_X:  delay_x_d = i_writedata[DELAY_W-1:0];
        OFF_DELAY_Y:  delay_y_d = i_writedata[DELAY_W-1:0];
        OFF_DELAY_Z:  delay_z_d = i_writedata[DELAY_W-1:0];
        OFF_AXI_CTRL: axi_rst_d = i_writedata[AXI_RST_BIT];
        default: ;
      endcase
    end

    if (acc && !mapped) err_set[ERR_UNMAPPED_BIT] = 1'b1;
    if (collide)        err_set[ERR_COLLIDE_BIT]  = 1'b1;
    // A new error event wins over a coincident write-1-to-clear
    err_d = (err_q & ~err_clr) | err_set;

    wait_d   = (state_d != IDLE);
    rvalid_d = (state_q == RD1);
  end

  // State and register update
  always_ff @(posedge avmm_clk) begin
    if (avmm_rst) begin
      state_q   <= IDLE;
      wait_q    <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      pat_sel_q <= '0;
      pkt_cnt_q <= '0;
      axi_rst_q <= 1'b0;
      err_q     <= '0;
      delay_x_q <= DELAY_W'(DEF_DELAY_X);
      delay_y_q <= DELAY_W'(DEF_DELAY_Y);
      delay_z_q <= DELAY_W'(DEF_DELAY_Z);
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      pat_sel_q <= pat_sel_d;
      pkt_cnt_q <= pkt_cnt_d;
      axi_rst_q <= axi_rst_d;
      err_q     <= err_d;
      delay_x_q <= delay_x_d;
      delay_y_q <= delay_y_d;
      delay_z_q <= delay_z_d;
    end
  end

  assign o_readdata      = rdata_q;
  assign o_readdatavalid = rvalid_q;
  assign o_waitrequest   = wait_q;
  assign o_start         = start_q;
  assign o_pat_sel       = pat_sel_q;
  assign o_pkt_cnt       = pkt_cnt_q;
  assign o_axi_rst       = axi_rst_q;
  assign o_delay_x       = delay_x_q;
  assign o_delay_y       = delay_y_q;
  assign o_delay_z       = delay_z_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_axist_csr_slave.sv
// Directed bench for axist_csr_slave: reset values, read latency, register
// writes, status reads, window coherence, error flags and reset mid-read.
module tb_axist_csr_slave;

  logic         avmm_clk = 1'b0;
  logic         avmm_rst;
  logic [31:0]  i_address;
  logic         i_write;
  logic         i_read;
  logic [31:0]  i_writedata;
  logic [31:0]  o_readdata;
  logic         o_readdatavalid;
  logic         o_waitrequest;
  logic [3:0]   i_link_sts;
  logic         i_align_done;
  logic         i_test_done;
  logic         i_test_pass;
  logic [255:0] i_dout_first;
  logic [255:0] i_dout_last;
  logic [255:0] i_din_first;
  logic [255:0] i_din_last;
  logic [15:0]  o_delay_x;
  logic [15:0]  o_delay_y;
  logic [15:0]  o_delay_z;
  logic         o_axi_rst;
  logic         o_start;
  logic [1:0]   o_pat_sel;
  logic [7:0]   o_pkt_cnt;
  logic [1:0]   o_dbg_state;

  int checks = 0;
  int errors = 0;

  axist_csr_slave dut (
    .avmm_clk        (avmm_clk),
    .avmm_rst        (avmm_rst),
    .i_address       (i_address),
    .i_write         (i_write),
    .i_read          (i_read),
    .i_writedata     (i_writedata),
    .o_readdata      (o_readdata),
    .o_readdatavalid (o_readdatavalid),
    .o_waitrequest   (o_waitrequest),
    .i_link_sts      (i_link_sts),
    .i_align_done    (i_align_done),
    .i_test_done     (i_test_done),
    .i_test_pass     (i_test_pass),
    .i_dout_first    (i_dout_first),
    .i_dout_last     (i_dout_last),
    .i_din_first     (i_din_first),
    .i_din_last      (i_din_last),
    .o_delay_x       (o_delay_x),
    .o_delay_y       (o_delay_y),
    .o_delay_z       (o_delay_z),
    .o_axi_rst       (o_axi_rst),
    .o_start         (o_start),
    .o_pat_sel       (o_pat_sel),
    .o_pkt_cnt       (o_pkt_cnt),
    .o_dbg_state     (o_dbg_state)
  );

  // Clock
  always #5 avmm_clk = ~avmm_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a cycle in which the pending request is accepted
  task automatic wait_accept(input string tag);
    int n = 0;
    @(negedge avmm_clk);
    while (o_waitrequest && n < 20) begin
      @(negedge avmm_clk);
      n++;
    end
    chk(tag, {31'd0, o_waitrequest}, 32'd0);
  endtask

  task automatic avmm_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge avmm_clk); #1;
    i_address   = a;
    i_writedata = d;
    i_write     = 1'b1;
    wait_accept("wr_accept");
    @(posedge avmm_clk); #1;
    i_write = 1'b0;
  endtask

  // Read with latency checks: stall+no valid at N+1, stall+valid at N+2,
  // idle and no valid at N+3
  task automatic avmm_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge avmm_clk); #1;
    i_address = a;
    i_read    = 1'b1;
    wait_accept("rd_accept");
    @(posedge avmm_clk); #1;
    i_read = 1'b0;
    @(negedge avmm_clk);
    chk("rd_lat1", {30'd0, o_waitrequest, o_readdatavalid}, 32'd2);
    @(negedge avmm_clk);
    chk("rd_lat2", {30'd0, o_waitrequest, o_readdatavalid}, 32'd3);
    d = o_readdata;
    @(negedge avmm_clk);
    chk("rd_lat3", {30'd0, o_waitrequest, o_readdatavalid}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    avmm_read(a, d);
    chk(tag, d, exp);
  endtask

  // Read and write in the same cycle; the read must be dropped
  task automatic collide(input logic [31:0] a, input logic [31:0] d);
    @(posedge avmm_clk); #1;
    i_address   = a;
    i_writedata = d;
    i_read      = 1'b1;
    i_write     = 1'b1;
    wait_accept("col_accept");
    @(posedge avmm_clk); #1;
    i_read  = 1'b0;
    i_write = 1'b0;
    repeat (3) begin
      @(negedge avmm_clk);
      chk("col_no_rvalid", {30'd0, o_waitrequest, o_readdatavalid}, 32'd0);
    end
  endtask

  logic [255:0] pat;
  logic [31:0]  rd;

  initial begin
    avmm_rst     = 1'b1;
    i_address    = '0;
    i_write      = 1'b0;
    i_read       = 1'b0;
    i_writedata  = '0;
    i_link_sts   = '0;
    i_align_done = 1'b0;
    i_test_done  = 1'b0;
    i_test_pass  = 1'b0;
    i_dout_first = '0;
    i_dout_last  = '0;
    i_din_first  = '0;
    i_din_last   = '0;

    // Reset values
    repeat (3) @(posedge avmm_clk);
    @(negedge avmm_clk);
    chk("rst_wait",   {31'd0, o_waitrequest}, 32'd1);
    chk("rst_rvalid", {31'd0, o_readdatavalid}, 32'd0);
    chk("rst_rdata",  o_readdata, 32'd0);
    chk("rst_start",  {31'd0, o_start}, 32'd0);
    chk("rst_ctrl",   {22'd0, o_pat_sel, o_pkt_cnt}, 32'd0);
    chk("rst_axi",    {31'd0, o_axi_rst}, 32'd0);
    chk("rst_dx",     {16'd0, o_delay_x}, 32'd12);
    chk("rst_dy",     {16'd0, o_delay_y}, 32'd32);
    chk("rst_dz",     {16'd0, o_delay_z}, 32'd6000);
    @(posedge avmm_clk); #1;
    avmm_rst = 1'b0;
    @(negedge avmm_clk);
    chk("post_rst_wait1", {31'd0, o_waitrequest}, 32'd1);
    @(negedge avmm_clk);
    chk("post_rst_wait0", {31'd0, o_waitrequest}, 32'd0);

    // Delay defaults via the bus
    rd_chk("rd_delay_x", 32'h5000_2000, 32'h0000_000C);
    rd_chk("rd_delay_y", 32'h5000_2004, 32'h0000_0020);
    rd_chk("rd_delay_z", 32'h5000_2008, 32'h0000_1770);
    rd_chk("rd_err0",    32'h5000_100C, 32'h0000_0000);

    // Packet control with start pulse
    avmm_write(32'h5000_1000, 32'h0000_1005);
    @(negedge avmm_clk);
    chk("start_hi", {31'd0, o_start}, 32'd1);
    chk("pat_sel",  {30'd0, o_pat_sel}, 32'd2);
    chk("pkt_cnt",  {24'd0, o_pkt_cnt}, 32'h10);
    @(negedge avmm_clk);
    chk("start_lo", {31'd0, o_start}, 32'd0);
    rd_chk("rd_tx_ctrl", 32'h5000_1000, 32'h0000_1004);

    // Delay write and readback
    avmm_write(32'h5000_2004, 32'hABCD_0123);
    rd_chk("rd_delay_y_wr", 32'h5000_2004, 32'h0000_0123);

    // Status registers
    i_link_sts = 4'hF; i_align_done = 1'b1; i_test_done = 1'b1; i_test_pass = 1'b1;
    rd_chk("rd_link_f", 32'h5000_1008, 32'h0000_000F);
    rd_chk("rd_ckr_b",  32'h5000_1004, 32'h0000_000B);
    i_link_sts = 4'h5; i_align_done = 1'b0; i_test_done = 1'b0; i_test_pass = 1'b1;
    rd_chk("rd_link_5", 32'h5000_1008, 32'h0000_0005);
    rd_chk("rd_ckr_1",  32'h5000_1004, 32'h0000_0001);

    // Window coherence on DOUT_FIRST
    for (int k = 0; k < 8; k++) pat[k*32 +: 32] = 32'h1111_1111 * k;
    i_dout_first = pat;
    rd_chk("win_w0", 32'h5000_4000, 32'h0000_0000);
    i_dout_first = ~pat;
    for (int k = 1; k < 8; k++) begin
      avmm_read(32'h5000_4000 + 32'(k * 4), rd);
      chk("win_wk", rd, pat[k*32 +: 32]);
    end
    rd_chk("win_resnap_w0", 32'h5000_4000, 32'hFFFF_FFFF);
    rd_chk("win_resnap_w1", 32'h5000_4004, 32'hEEEE_EEEE);
    // Other windows have not been snapshotted
    i_din_first = {8{32'hDEAD_BEEF}};
    rd_chk("win_indep", 32'h5000_420C, 32'h0000_0000);

    // Unmapped accesses and error clearing
    rd_chk("rd_unmapped", 32'h5000_9000, 32'h0000_0000);
    rd_chk("err_unmapped", 32'h5000_100C, 32'h0000_0001);
    avmm_write(32'h5000_100C, 32'h0000_0001);
    rd_chk("err_cleared", 32'h5000_100C, 32'h0000_0000);
    rd_chk("rd_bad_base", 32'h6000_2000, 32'h0000_0000);
    rd_chk("err_bad_base", 32'h5000_100C, 32'h0000_0001);
    avmm_write(32'h5000_100C, 32'h0000_0003);
    avmm_write(32'h5000_1004, 32'hFFFF_FFFF);
    rd_chk("err_ro_write", 32'h5000_100C, 32'h0000_0000);

    // Read+write collision
    collide(32'h5000_3000, 32'h0000_0001);
    chk("col_axi_rst", {31'd0, o_axi_rst}, 32'd1);
    rd_chk("err_collide", 32'h5000_100C, 32'h0000_0002);
    // Clearing ERR[1] by a colliding write: the new collision wins
    collide(32'h5000_100C, 32'h0000_0002);
    rd_chk("err_set_wins", 32'h5000_100C, 32'h0000_0002);
    avmm_write(32'h5000_100C, 32'h0000_0002);
    rd_chk("err_final_clr", 32'h5000_100C, 32'h0000_0000);

    // Reset asserted during RD1
    avmm_write(32'h5000_2000, 32'h0000_0055);
    @(negedge avmm_clk);
    chk("dx_written", {16'd0, o_delay_x}, 32'h55);
    @(posedge avmm_clk); #1;
    i_address = 32'h5000_2000;
    i_read    = 1'b1;
    wait_accept("rst_rd_accept");
    @(posedge avmm_clk); #1;
    i_read   = 1'b0;
    avmm_rst = 1'b1;
    repeat (3) begin
      @(negedge avmm_clk);
      chk("rst_mid_rd", {30'd0, o_waitrequest, o_readdatavalid}, 32'd2);
    end
    chk("rst_mid_dx",  {16'd0, o_delay_x}, 32'd12);
    chk("rst_mid_dy",  {16'd0, o_delay_y}, 32'd32);
    chk("rst_mid_axi", {31'd0, o_axi_rst}, 32'd0);
    @(posedge avmm_clk); #1;
    avmm_rst = 1'b0;
    @(negedge avmm_clk);
    chk("rst2_wait1", {30'd0, o_waitrequest, o_readdatavalid}, 32'd2);
    @(negedge avmm_clk);
    chk("rst2_wait0", {30'd0, o_waitrequest, o_readdatavalid}, 32'd0);
    rd_chk("rd_dx_after_rst", 32'h5000_2000, 32'h0000_000C);
    rd_chk("rd_tx_after_rst", 32'h5000_1000, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
